// File: rtl/vec3_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vec3_subtractor_pkg
// Brief    : Shared h3dge word width, saturation limits and FSM encoding.
// Revision : 1.0
// ============================================================================
package vec3_subtractor_pkg;

   localparam int          H3DGE_WORD_W  = 32;
   localparam logic [31:0] H3DGE_SAT_POS = 32'h7FFF_FFFF;
   localparam logic [31:0] H3DGE_SAT_NEG = 32'h8000_0000;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SUB_X = 3'd1,
      ST_SUB_Y = 3'd2,
      ST_SUB_Z = 3'd3,
      ST_OUT   = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/vec3_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module   : vec3_subtractor_if
// Brief    : Operand/result valid-ready bundle for the vector subtractor.
// Revision : 1.0
// ============================================================================
interface vec3_subtractor_if
   import vec3_subtractor_pkg::*;
#(
   parameter int WIDTH = H3DGE_WORD_W
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a_x, a_y, a_z;
   logic [WIDTH-1:0] b_x, b_y, b_z;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] c_x, c_y, c_z;
   logic [2:0]       ovf;
   logic             busy;

   modport master (
      output in_valid, a_x, a_y, a_z, b_x, b_y, b_z, out_ready,
      input  in_ready, out_valid, c_x, c_y, c_z, ovf, busy
   );

   modport slave (
      input  in_valid, a_x, a_y, a_z, b_x, b_y, b_z, out_ready,
      output in_ready, out_valid, c_x, c_y, c_z, ovf, busy
   );
endinterface
`default_nettype wire

// File: rtl/vec3_subtractor_sub_sat32.sv
`default_nettype none
// ============================================================================
// Module   : sub_sat32
// Brief    : Combinational two's-complement subtract with optional clamping.
// Revision : 1.0
// ============================================================================
module sub_sat32
   import vec3_subtractor_pkg::*;
#(
   parameter int WIDTH = H3DGE_WORD_W
) (
   input  wire logic [WIDTH-1:0] a,
   input  wire logic [WIDTH-1:0] b,
   input  wire logic             sat_en,
   output logic      [WIDTH-1:0] d,
   output logic                  ovf
);
   localparam logic [WIDTH-1:0] c_one     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] c_sat_pos = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] c_sat_neg = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0] w_diff;

   assign w_diff = a + ~b + c_one;
   // Overflow only possible when operand signs differ and the sign flips.
   assign ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);

   always_comb begin
      d = w_diff;
      if (sat_en && ovf) begin
         d = a[WIDTH-1] ? c_sat_neg : c_sat_pos;
      end
   end
endmodule
`default_nettype wire

// File: rtl/vec3_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : vec3_subtractor
// Brief    : C = A - B on 3-component vectors, one shared subtractor over 3 cycles.
// Revision : 1.0
// ============================================================================
module vec3_subtractor
   import vec3_subtractor_pkg::*;
#(
   parameter int WIDTH    = H3DGE_WORD_W,
   parameter int SATURATE = 1
) (
   input wire logic         clk,
   input wire logic         rst_n,
   vec3_subtractor_if.slave bus
);
   state_t           r_state;
   logic [WIDTH-1:0] r_a_x, r_a_y, r_a_z;
   logic [WIDTH-1:0] r_b_x, r_b_y, r_b_z;
   logic [WIDTH-1:0] r_c_x, r_c_y, r_c_z;
   logic [2:0]       r_ovf;
   logic             r_out_valid;
   logic             r_busy;

   logic             w_in_ready;
   logic             w_accept;
   logic [WIDTH-1:0] w_op_a, w_op_b, w_diff;
   logic             w_ovf;

   // OUT can hand off and accept in the same cycle for back-to-back vectors.
   assign w_in_ready = (r_state == ST_IDLE) || ((r_state == ST_OUT) && bus.out_ready);
   assign w_accept   = bus.in_valid && w_in_ready;

   always_comb begin
      w_op_a = '0;
      w_op_b = '0;
      case (r_state)
         ST_SUB_X: begin w_op_a = r_a_x; w_op_b = r_b_x; end
         ST_SUB_Y: begin w_op_a = r_a_y; w_op_b = r_b_y; end
         ST_SUB_Z: begin w_op_a = r_a_z; w_op_b = r_b_z; end
         default:  begin w_op_a = '0;    w_op_b = '0;    end
      endcase
   end

   sub_sat32 #(
      .WIDTH (WIDTH)
   ) u_sub (
      .a      (w_op_a),
      .b      (w_op_b),
      .sat_en (SATURATE != 0),
      .d      (w_diff),
      .ovf    (w_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_a_x       <= '0; r_a_y <= '0; r_a_z <= '0;
         r_b_x       <= '0; r_b_y <= '0; r_b_z <= '0;
         r_c_x       <= '0; r_c_y <= '0; r_c_z <= '0;
         r_ovf       <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         if (w_accept) begin
            r_a_x <= bus.a_x; r_a_y <= bus.a_y; r_a_z <= bus.a_z;
            r_b_x <= bus.b_x; r_b_y <= bus.b_y; r_b_z <= bus.b_z;
            r_ovf <= '0;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state <= ST_SUB_X;
                  r_busy  <= 1'b1;
               end
            end
            ST_SUB_X: begin
               r_c_x    <= w_diff;
               r_ovf[0] <= w_ovf;
               r_state  <= ST_SUB_Y;
            end
            ST_SUB_Y: begin
               r_c_y    <= w_diff;
               r_ovf[1] <= w_ovf;
               r_state  <= ST_SUB_Z;
            end
            ST_SUB_Z: begin
               r_c_z       <= w_diff;
               r_ovf[2]    <= w_ovf;
               r_state     <= ST_OUT;
               r_out_valid <= 1'b1;
            end
            ST_OUT: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  if (w_accept) begin
                     r_state <= ST_SUB_X;
                  end else begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.c_x       = r_c_x;
   assign bus.c_y       = r_c_y;
   assign bus.c_z       = r_c_z;
   assign bus.ovf       = r_ovf;
   assign bus.busy      = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_vec3_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec3_subtractor
// Brief    : Self-checking bench; saturating and wrapping DUTs run in lockstep.
// Revision : 1.0
// ============================================================================
module tb_vec3_subtractor
   import vec3_subtractor_pkg::*;
;
   typedef struct packed {
      logic [2:0]  ovf;
      logic [31:0] cz;
      logic [31:0] cy;
      logic [31:0] cx;
   } res_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_total = 0;
   int   n_pass  = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   vec3_subtractor_if #(.WIDTH(32)) if_s ();
   vec3_subtractor_if #(.WIDTH(32)) if_w ();

   assign if_w.in_valid  = if_s.in_valid;
   assign if_w.out_ready = if_s.out_ready;
   assign if_w.a_x = if_s.a_x;
   assign if_w.a_y = if_s.a_y;
   assign if_w.a_z = if_s.a_z;
   assign if_w.b_x = if_s.b_x;
   assign if_w.b_y = if_s.b_y;
   assign if_w.b_z = if_s.b_z;

   vec3_subtractor #(.WIDTH(32), .SATURATE(1)) dut_sat (.clk(clk), .rst_n(rst_n), .bus(if_s));
   vec3_subtractor #(.WIDTH(32), .SATURATE(0)) dut_wrap (.clk(clk), .rst_n(rst_n), .bus(if_w));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: exact integer difference, then clamp or truncate.
   function automatic logic [32:0] ref_one(input logic [31:0] a, input logic [31:0] b, input bit sat);
      longint      diff;
      bit          o;
      logic [31:0] r;
      diff = longint'($signed(a)) - longint'($signed(b));
      o    = (diff > 64'sd2147483647) || (diff < -64'sd2147483648);
      r    = diff[31:0];
      if (o && sat) r = (diff > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      return {o, r};
   endfunction

   function automatic res_t model(input logic [31:0] ax, ay, az, bx, by, bz, input bit sat);
      logic [32:0] rx, ry, rz;
      res_t        r;
      rx = ref_one(ax, bx, sat);
      ry = ref_one(ay, by, sat);
      rz = ref_one(az, bz, sat);
      r.cx  = rx[31:0];
      r.cy  = ry[31:0];
      r.cz  = rz[31:0];
      r.ovf = {rz[32], ry[32], rx[32]};
      return r;
   endfunction

   task automatic set_ops(input logic [31:0] ax, ay, az, bx, by, bz);
      if_s.a_x = ax; if_s.a_y = ay; if_s.a_z = az;
      if_s.b_x = bx; if_s.b_y = by; if_s.b_z = bz;
   endtask

   task automatic check_result(input string tag, input res_t es, input res_t ew);
      check({tag, ".sat.cx"},  64'(if_s.c_x), 64'(es.cx));
      check({tag, ".sat.cy"},  64'(if_s.c_y), 64'(es.cy));
      check({tag, ".sat.cz"},  64'(if_s.c_z), 64'(es.cz));
      check({tag, ".sat.ovf"}, 64'(if_s.ovf), 64'(es.ovf));
      check({tag, ".wrap.cx"}, 64'(if_w.c_x), 64'(ew.cx));
      check({tag, ".wrap.cy"}, 64'(if_w.c_y), 64'(ew.cy));
      check({tag, ".wrap.cz"}, 64'(if_w.c_z), 64'(ew.cz));
      check({tag, ".wrap.ovf"}, 64'(if_w.ovf), 64'(ew.ovf));
   endtask

   // Present one vector, wait for acceptance, then expect out_valid on the
   // third edge after the accepting edge. Leaves the bench in the OUT cycle.
   task automatic run_vec(input string tag, input logic [31:0] ax, ay, az, bx, by, bz);
      int n = 0;
      set_ops(ax, ay, az, bx, by, bz);
      if_s.in_valid  = 1'b1;
      if_s.out_ready = 1'b1;
      while (!if_s.in_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      check({tag, ".accept_timeout"}, 64'(n < 20), 64'd1);
      @(posedge clk); #1;
      if_s.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check({tag, ".early_valid"}, 64'(if_s.out_valid), 64'd0);
         @(posedge clk); #1;
      end
      check({tag, ".out_valid"}, 64'(if_s.out_valid), 64'd1);
      check_result(tag, model(ax, ay, az, bx, by, bz, 1'b1), model(ax, ay, az, bx, by, bz, 1'b0));
   endtask

   task automatic to_idle(input string tag);
      @(posedge clk); #1;
      check({tag, ".idle_busy"},  64'(if_s.busy),      64'd0);
      check({tag, ".idle_valid"}, 64'(if_s.out_valid), 64'd0);
   endtask

   initial begin
      res_t        e1s, e1w, e2s, e2w;
      res_t        qs[$], qw[$];
      logic [31:0] sv[8][6];
      int          idx, got, last_cyc, cyc;

      rst_n          = 1'b0;
      if_s.in_valid  = 1'b0;
      if_s.out_ready = 1'b0;
      set_ops('0, '0, '0, '0, '0, '0);
      #12;
      check("rst.in_ready",  64'(if_s.in_ready),  64'd1);
      check("rst.out_valid", 64'(if_s.out_valid), 64'd0);
      check("rst.busy",      64'(if_s.busy),      64'd0);
      check("rst.c",         {if_s.c_x, if_s.c_y | if_s.c_z}, 64'd0);
      check("rst.ovf",       64'(if_s.ovf),       64'd0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic vector
      run_vec("basic", 32'd10, 32'd20, 32'd30, 32'd3, 32'd25, 32'd30);
      check("basic.cx_lit", 64'(if_s.c_x), 64'd7);
      check("basic.cy_lit", 64'(if_s.c_y), 64'hFFFF_FFFB);
      check("basic.cz_lit", 64'(if_s.c_z), 64'd0);
      check("basic.busy",   64'(if_s.busy), 64'd1);
      to_idle("basic");

      // Positive overflow on x
      run_vec("posovf", 32'h7FFF_FFFF, 32'd5, 32'd5, 32'hFFFF_FFFF, 32'd2, 32'd7);
      check("posovf.sat_cx",  64'(if_s.c_x), 64'(H3DGE_SAT_POS));
      check("posovf.wrap_cx", 64'(if_w.c_x), 64'h8000_0000);
      check("posovf.ovf",     64'(if_s.ovf), 64'b001);
      to_idle("posovf");

      // Negative overflow on z, none on y
      run_vec("negovf", 32'd1, 32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, 32'd1);
      check("negovf.sat_cz",  64'(if_s.c_z), 64'(H3DGE_SAT_NEG));
      check("negovf.wrap_cz", 64'(if_w.c_z), 64'h7FFF_FFFF);
      check("negovf.cy",      64'(if_s.c_y), 64'h8000_0000);
      check("negovf.ovf",     64'(if_s.ovf), 64'b100);
      to_idle("negovf");

      // Backpressure: junk operands offered while the result is held
      e1s = model(32'd100, 32'hFFFF_FF00, 32'h8000_0001, 32'd1, 32'd5, 32'd2, 1'b1);
      e1w = model(32'd100, 32'hFFFF_FF00, 32'h8000_0001, 32'd1, 32'd5, 32'd2, 1'b0);
      set_ops(32'd100, 32'hFFFF_FF00, 32'h8000_0001, 32'd1, 32'd5, 32'd2);
      if_s.in_valid  = 1'b1;
      if_s.out_ready = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         set_ops($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
         @(posedge clk); #1;
      end
      check("bp.out_valid", 64'(if_s.out_valid), 64'd1);
      for (int i = 0; i < 5; i++) begin
         set_ops($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
         #1;
         check("bp.in_ready_low", 64'(if_s.in_ready),  64'd0);
         check("bp.held_valid",   64'(if_s.out_valid), 64'd1);
         check_result("bp.hold", e1s, e1w);
         @(posedge clk); #1;
      end
      e2s = model(32'd7, 32'd8, 32'd9, 32'd10, 32'd4, 32'hFFFF_FFFF, 1'b1);
      e2w = model(32'd7, 32'd8, 32'd9, 32'd10, 32'd4, 32'hFFFF_FFFF, 1'b0);
      set_ops(32'd7, 32'd8, 32'd9, 32'd10, 32'd4, 32'hFFFF_FFFF);
      if_s.out_ready = 1'b1;
      #1;
      check("bp.in_ready_release", 64'(if_s.in_ready), 64'd1);
      @(posedge clk); #1;
      if_s.in_valid = 1'b0;
      check("bp.b2b_busy",  64'(if_s.busy),      64'd1);
      check("bp.b2b_valid", 64'(if_s.out_valid), 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
      end
      check("bp.next_valid", 64'(if_s.out_valid), 64'd1);
      check_result("bp.next", e2s, e2w);
      to_idle("bp");

      // Streaming: 8 random vectors, both handshakes held high
      for (int k = 0; k < 8; k++)
         for (int j = 0; j < 6; j++)
            sv[k][j] = (($urandom & 3) == 0) ? 32'h8000_0000 ^ ($urandom & 1) : $urandom;
      idx = 0; got = 0; last_cyc = 0; cyc = 0;
      set_ops(sv[0][0], sv[0][1], sv[0][2], sv[0][3], sv[0][4], sv[0][5]);
      if_s.in_valid  = 1'b1;
      if_s.out_ready = 1'b1;
      while (got < 8 && cyc < 100) begin
         if (if_s.out_valid) begin
            if (qs.size() > 0) begin
               check_result("stream", qs.pop_front(), qw.pop_front());
            end else begin
               check("stream.spurious", 64'd1, 64'd0);
            end
            if (got > 0) check("stream.spacing", 64'(cyc - last_cyc), 64'd4);
            last_cyc = cyc;
            got++;
         end
         if (if_s.in_valid && if_s.in_ready) begin
            qs.push_back(model(sv[idx][0], sv[idx][1], sv[idx][2], sv[idx][3], sv[idx][4], sv[idx][5], 1'b1));
            qw.push_back(model(sv[idx][0], sv[idx][1], sv[idx][2], sv[idx][3], sv[idx][4], sv[idx][5], 1'b0));
            idx++;
         end
         @(posedge clk); #1;
         cyc++;
         if (idx < 8) set_ops(sv[idx][0], sv[idx][1], sv[idx][2], sv[idx][3], sv[idx][4], sv[idx][5]);
         else         if_s.in_valid = 1'b0;
      end
      check("stream.count",    64'(got), 64'd8);
      check("stream.accepted", 64'(idx), 64'd8);
      check("stream.drained",  64'(qs.size()), 64'd0);
      @(posedge clk); #1;
      check("stream.idle", 64'(if_s.busy), 64'd0);

      // Asynchronous reset while in SUB_Y
      set_ops(32'd1000, 32'd2000, 32'd3000, 32'd1, 32'd2, 32'd3);
      if_s.in_valid = 1'b1;
      @(posedge clk); #1;
      if_s.in_valid = 1'b0;
      @(posedge clk); #3;
      check("arst.pre_busy", 64'(if_s.busy), 64'd1);
      check("arst.pre_cx",   64'(if_s.c_x),  64'd999);
      rst_n = 1'b0;
      #1;
      check("arst.out_valid", 64'(if_s.out_valid), 64'd0);
      check("arst.busy",      64'(if_s.busy),      64'd0);
      check("arst.in_ready",  64'(if_s.in_ready),  64'd1);
      check("arst.c",         {if_s.c_x, if_s.c_y | if_s.c_z}, 64'd0);
      check("arst.ovf",       64'(if_s.ovf),       64'd0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("arst.post_busy", 64'(if_s.busy), 64'd0);
      run_vec("arst.fresh", 32'h8000_0000, 32'd50, 32'd0, 32'd1, 32'd60, 32'h8000_0000);
      to_idle("arst.fresh");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
`default_nettype wire
